elevator_ctrl: RTL

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

---
 rtl/elevator_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - SCAN elevator controller with per-floor call latching, travel and door timing
module elevator_ctrl #(
   parameter int N_FLOORS      = 3,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_FLOORS-1:0] button_n,
   output logic [N_FLOORS-1:0] led,
   output logic [N_FLOORS-1:0] floor,
   output logic                door,
   output logic                moving,
   output logic                dir_up
);

   localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0]       T_LAST = CW'(TRAVEL_CYCLES - 1);
   localparam logic [CW-1:0]       D_LOAD = CW'(DOOR_CYCLES);
   localparam logic [CW-1:0]       C_ONE  = CW'(1);
   localparam logic [N_FLOORS-1:0] ONE    = N_FLOORS'(1);

   typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [N_FLOORS-1:0] button_q;
   logic [N_FLOORS-1:0] press;
   logic [N_FLOORS-1:0] press_led;
   logic [N_FLOORS-1:0] at_or_below;
   logic [N_FLOORS-1:0] above;
   logic [N_FLOORS-1:0] below;
   logic [N_FLOORS-1:0] next_floor;
   logic                cur_press;

   always_comb begin
      press       = button_q & ~button_n;
      cur_press   = |(press & floor);
      // Current-floor presses are answered by the door, not latched, unless the car is travelling.
      press_led   = (state == MOVING) ? press : (press & ~floor);
      at_or_below = (floor << 1) - ONE;
      above       = led & ~at_or_below;
      below       = led & (floor - ONE);
      next_floor  = dir_up ? (floor << 1) : (floor >> 1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         button_q <= '1;
         led      <= '0;
         floor    <= ONE;
         door     <= 1'b0;
         moving   <= 1'b0;
         dir_up   <= 1'b1;
      end else begin
         button_q <= button_n;
         led      <= led | press_led;
         case (state)
            IDLE: begin
               if (cur_press) begin
                  state <= DOOR_OPEN;
                  door  <= 1'b1;
                  cnt   <= D_LOAD;
               end else if (|led) begin
                  // Keep heading the same way while work remains there, otherwise reverse.
                  state  <= MOVING;
                  moving <= 1'b1;
                  cnt    <= '0;
                  dir_up <= dir_up ? (|above) : ~(|below);
               end
            end
            MOVING: begin
               if (cnt == T_LAST) begin
                  floor <= next_floor;
                  if (|(led & next_floor)) begin
                     led    <= (led | press_led) & ~next_floor;
                     state  <= DOOR_OPEN;
                     moving <= 1'b0;
                     door   <= 1'b1;
                     cnt    <= D_LOAD;
                  end else begin
                     cnt <= '0;
                  end
               end else begin
                  cnt <= cnt + C_ONE;
               end
            end
            DOOR_OPEN: begin
               if (cur_press) begin
                  cnt <= D_LOAD;
               end else if (cnt == C_ONE) begin
                  state <= IDLE;
                  door  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - C_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
